// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: access-type encodings,
// FSM states, byte-enable constants and access legality helpers.
package mem_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  function automatic logic type_legal(input logic [2:0] t);
    case (t)
      3'b011, 3'b110, 3'b111: return 1'b0;
      default:                return 1'b1;
    endcase
  endfunction

  // Width comes from the low two bits; BU/HU share the B/H rules.
  function automatic logic is_aligned(input logic [2:0] t, input logic [1:0] off);
    case (t[1:0])
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects the addressed byte/half of the bus
// word and sign- or zero-extends it according to the access type.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_type,
  output logic [31:0] o_data
);

  logic [31:0] w_shift_b;
  logic [31:0] w_shift_h;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift_b = i_rdata >> {i_off, 3'b000};
  assign w_shift_h = i_rdata >> {i_off[1], 4'b0000};
  assign w_byte    = w_shift_b[7:0];
  assign w_half    = w_shift_h[15:0];

  always_comb begin
    case (i_type)
      MT_B:    o_data = {{24{w_byte[7]}}, w_byte};
      MT_BU:   o_data = {24'h0, w_byte};
      MT_H:    o_data = {{16{w_half[15]}}, w_half};
      MT_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one request/ready bus transaction per
// load/store, with store lane alignment, load extension and pipeline stall.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mem_rw_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        pause,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  state_e      r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_type;
  logic [1:0]  r_off;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [31:0] r_load_data;
  logic        r_misalign;
  logic        r_bus_err;

  logic        w_access;
  logic        w_legal;
  logic        w_aligned;
  logic        w_go;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_access  = mem_rd | mem_wr;
  assign w_legal   = type_legal(mem_rw_type);
  assign w_aligned = is_aligned(mem_rw_type, addr[1:0]);
  assign w_go      = w_access & w_legal & w_aligned;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES) - 32'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_be    = BE_ALL;
    w_wdata = wdata;
    if (mem_wr) begin
      case (mem_rw_type[1:0])
        2'b00: begin
          w_be    = BE_BYTE0 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          w_be    = addr[1] ? BE_HI_HALF : BE_LO_HALF;
          w_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .i_rdata (bus_rdata),
    .i_off   (r_off),
    .i_type  (r_type),
    .o_data  (w_load)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_type      <= '0;
      r_off       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= BE_NONE;
      r_load_data <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state     <= S_REQ;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_wr;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_type      <= mem_rw_type;
            r_off       <= addr[1:0];
            r_cnt       <= '0;
          end else if (w_access && w_legal) begin
            r_misalign <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            if (!r_bus_we) r_load_data <= w_load;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
            r_bus_req   <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        // EX/MEM still holds the finished instruction here, so inputs are ignored.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pause     = ~rst & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ));
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;
  assign load_data = r_load_data;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit: stimulus pushes expected
// bus and completion records, a monitor pops and compares them.
module tb_mem_access_unit;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  mem_rw_type;
  logic [31:0] addr, wdata;
  logic        pause, misalign, bus_err, bus_req, bus_we, bus_ready;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rw_type(mem_rw_type),
    .addr(addr), .wdata(wdata), .pause(pause), .load_data(load_data), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          pause_len;
    bit          err;
    logic [31:0] load;
  } done_exp_t;

  bus_exp_t    q_bus[$];
  done_exp_t   q_done[$];
  int          q_mis[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          rsp_lat;
  logic [31:0] rsp_rdata;
  logic [31:0] model_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] d);
    int unsigned v;
    int unsigned off;
    off = a % 4;
    case (t)
      3'd0, 3'd4: v = (d >> (8 * off)) & 32'hFF;
      3'd1, 3'd5: v = (d >> (16 * (off / 2))) & 32'hFFFF;
      default:    v = d;
    endcase
    if (t == 3'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
    if (t == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Responder: ready arrives in REQ cycle rsp_lat+1; noise outside REQ.
  initial begin : responder
    int cnt;
    cnt       = 0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req && !rst) begin
        cnt++;
        bus_ready = (cnt > rsp_lat);
        bus_rdata = bus_ready ? rsp_rdata : $urandom;
      end else begin
        cnt       = 0;
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    bit        prev_req, prev_pause, done_now;
    int        run;
    bus_exp_t  cur;
    done_exp_t d;
    prev_req   = 1'b0;
    prev_pause = 1'b0;
    run        = 0;
    cur        = '{we: 1'b0, addr: '0, be: '0, wdata: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req   = 1'b0;
        prev_pause = 1'b0;
        run        = 0;
      end else begin
        if (bus_req) begin
          if (!prev_req) begin
            check("req_expected", 32'(q_bus.size() > 0), 32'd1);
            if (q_bus.size() > 0) cur = q_bus.pop_front();
          end
          check("bus_we", bus_we, cur.we);
          check("bus_addr", bus_addr, cur.addr);
          check("bus_be", bus_be, cur.be);
          if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
        end
        done_now = prev_pause && !pause;
        if (pause) run++;
        if (done_now) begin
          check("done_expected", 32'(q_done.size() > 0), 32'd1);
          if (q_done.size() > 0) begin
            d = q_done.pop_front();
            check("pause_len", run, d.pause_len);
            check("bus_err_done", bus_err, d.err);
            check("load_data", load_data, d.load);
            check("req_low_in_done", bus_req, 0);
          end
          run = 0;
        end else begin
          check("bus_err_quiet", bus_err, 0);
        end
        if (misalign) begin
          check("misalign_expected", 32'(q_mis.size() > 0), 32'd1);
          if (q_mis.size() > 0) void'(q_mis.pop_front());
          check("misalign_no_req", bus_req, 0);
        end
        prev_req   = bus_req;
        prev_pause = pause;
      end
    end
  end

  task automatic issue(input bit wr, input bit rd, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rdat);
    bit        any, legal, mis, go;
    int        sz, bound;
    bus_exp_t  bx;
    done_exp_t dx;
    any   = wr | rd;
    legal = !(t == 3'd3 || t == 3'd6 || t == 3'd7);
    case (t[1:0])
      2'd0:    sz = 1;
      2'd1:    sz = 2;
      default: sz = 4;
    endcase
    mis = any && legal && (a % sz != 0);
    go  = any && legal && !mis;
    rsp_lat   = lat;
    rsp_rdata = rdat;
    if (go) begin
      bx.we    = wr;
      bx.addr  = a & ~32'd3;
      bx.be    = !wr ? 4'hF : (sz == 1) ? 4'(1 << (a % 4)) : (sz == 2) ? 4'(3 << (a % 4)) : 4'hF;
      bx.wdata = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      q_bus.push_back(bx);
      if (lat >= int'(TO)) begin
        dx.err = 1'b1;
        dx.pause_len = 1 + int'(TO);
        model_load = '0;
      end else begin
        dx.err = 1'b0;
        dx.pause_len = lat + 2;
        if (!wr) model_load = ref_load(t, a, rdat);
      end
      dx.load = model_load;
      q_done.push_back(dx);
    end else if (mis) begin
      q_mis.push_back(1);
    end
    mem_wr = wr; mem_rd = rd; mem_rw_type = t; addr = a; wdata = wd;
    if (go) begin
      bound = 0;
      do begin
        @(negedge clk);
        bound++;
      end while (pause && bound < 200);
      check("access_completes", pause, 0);
    end else begin
      @(negedge clk);
      check("no_pause", pause, 0);
    end
    @(posedge clk); #1;
    mem_wr = 1'b0; mem_rd = 1'b0;
    mem_rw_type = 3'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit          wr, rd;
    logic [2:0]  t;
    int          lat, gap, sel;
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_rw_type = '0; addr = '0; wdata = '0;
    rsp_lat = 0; rsp_rdata = '0; model_load = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_misalign", misalign, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_load_data", load_data, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_pause", pause, 0);
    @(posedge clk); #1 rst = 1'b0;

    issue(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 0, $urandom);
    issue(0, 1, 3'd0, 32'h103, $urandom, 0, 32'h80FF0000);
    check("lb_sign_ext", load_data, 32'hFFFFFF80);
    issue(0, 1, 3'd4, 32'h103, $urandom, 0, 32'h80FF0000);
    check("lbu_zero_ext", load_data, 32'h00000080);
    issue(1, 0, 3'd1, 32'h202, 32'h1234ABCD, 0, $urandom);
    issue(0, 1, 3'd2, 32'h101, $urandom, 0, $urandom);
    issue(0, 1, 3'd3, 32'h100, $urandom, 0, $urandom);
    issue(1, 1, 3'd0, 32'h001, 32'hA5A5A55A, 0, $urandom);
    issue(0, 1, 3'd2, 32'h300, $urandom, 4, 32'h13579BDF);
    issue(0, 1, 3'd2, 32'h304, $urandom, 1000, $urandom);
    check("timeout_load_zero", load_data, 32'h0);
    issue(0, 1, 3'd5, 32'h302, $urandom, 1, 32'h8001_7FFF);

    // Abort a load mid-REQ with reset, then run a clean LW.
    rsp_lat = 1000;
    q_bus.push_back('{we: 1'b0, addr: 32'h40, be: 4'hF, wdata: '0});
    mem_rd = 1'b1; mem_rw_type = 3'd2; addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_bus_req", bus_req, 0);
    check("abort_pause", pause, 0);
    check("abort_load_data", load_data, 0);
    mem_rd = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    model_load = '0;
    issue(0, 1, 3'd2, 32'h44, $urandom, 0, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      wr  = 1'($urandom_range(0, 1));
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel < 8) begin
        wr = 1'b0;
        rd = 1'b0;
      end
      if (wr) t = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
      else    t = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 99);
      if (sel < 85)      lat = $urandom_range(0, 3);
      else if (sel < 92) lat = int'(TO) - 2;
      else if (sel < 97) lat = int'(TO);
      else               lat = 1000;
      issue(wr, rd, t, $urandom, $urandom, lat, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("q_bus_drained", q_bus.size(), 0);
    check("q_done_drained", q_done.size(), 0);
    check("q_mis_drained", q_mis.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
